// File: rtl/oddr_gearbox_pkg.sv
// Shared sizing helpers and constants for the ODDR parallel-to-DDR gearbox.
package oddr_gearbox_pkg;

    localparam int STAT_W = 16;

    function automatic int beats(input int data_w);
        return data_w / 2;
    endfunction

    // One-beat words still get a 1-bit counter so the port never collapses to zero width.
    function automatic int cnt_w(input int data_w);
        int b;
        b = beats(data_w);
        return (b <= 1) ? 1 : $clog2(b);
    endfunction

endpackage

// File: rtl/oddr_gearbox_skid.sv
// One-entry hold register in front of the gearbox shifter; refills in the
// same edge it hands its word to the shifter so the lane runs back to back.
module oddr_gearbox_skid
    import oddr_gearbox_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              C,
    input  logic              R_N,
    input  logic              CE,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    input  logic              LOAD,
    output logic [DATA_W-1:0] HOLD,
    output logic              HV,
    output logic              IN_READY
);

    logic [DATA_W-1:0] r_hold;
    logic              r_hv;
    logic              w_ready;
    logic              w_accept;

    assign w_ready  = CE && (!r_hv || LOAD);
    assign w_accept = IN_VALID && w_ready;

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            r_hold <= '0;
            r_hv   <= 1'b0;
        end else if (CE) begin
            if (w_accept) begin
                r_hold <= IN_DATA;
                r_hv   <= 1'b1;
            end else if (LOAD) begin
                r_hv   <= 1'b0;
            end
        end
    end

    assign HOLD     = r_hold;
    assign HV       = r_hv;
    assign IN_READY = w_ready;

endmodule

// File: rtl/oddr_gearbox.sv
// Parallel-to-DDR gearbox feeding ODDR D1/D2, LSB pair first, INIT level when idle.
// Optional statistics counters are enabled with `define ODDR_GEARBOX_STATS_EN.
module oddr_gearbox
    import oddr_gearbox_pkg::*;
#(
    parameter int   DATA_W = 8,
    parameter logic INIT   = 1'b0
) (
    input  logic              C,
    input  logic              R_N,
    input  logic              CE,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              D1,
    output logic              D2,
    output logic              ACTIVE,
    output logic              UNDERRUN
`ifdef ODDR_GEARBOX_STATS_EN
    ,
    output logic [STAT_W-1:0] WORD_CNT,
    output logic [STAT_W-1:0] UNDERRUN_CNT
`endif
);

    localparam int BEATS = beats(DATA_W);
    localparam int CNT_W = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [DATA_W-1:0] IDLE_WORD = {DATA_W{INIT}};
    // Top two bit positions, refilled with INIT as the word shifts down.
    localparam logic [DATA_W-1:0] TOP_MASK = ~({DATA_W{1'b1}} >> 2);

    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_active;
    logic              r_underrun;

    logic [DATA_W-1:0] w_hold;
    logic              w_hv;
    logic              w_last;
    logic              w_load;
    logic [DATA_W-1:0] w_shifted;

    assign w_last    = r_active && (r_cnt == LAST_CNT);
    assign w_load    = w_hv && (!r_active || w_last);
    assign w_shifted = (r_sr >> 2) | (IDLE_WORD & TOP_MASK);

    oddr_gearbox_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .C        (C),
        .R_N      (R_N),
        .CE       (CE),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .LOAD     (w_load),
        .HOLD     (w_hold),
        .HV       (w_hv),
        .IN_READY (IN_READY)
    );

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            r_sr       <= IDLE_WORD;
            r_cnt      <= '0;
            r_active   <= 1'b0;
            r_underrun <= 1'b0;
        end else if (CE) begin
            if (w_load) begin
                r_sr     <= w_hold;
                r_cnt    <= '0;
                r_active <= 1'b1;
            end else if (r_active && !w_last) begin
                r_sr     <= w_shifted;
                r_cnt    <= r_cnt + 1'b1;
            end else begin
                r_sr     <= IDLE_WORD;
                r_active <= 1'b0;
            end
            r_underrun <= w_last && !w_hv;
        end else begin
            r_underrun <= 1'b0;
        end
    end

    assign D1       = r_sr[0];
    assign D2       = r_sr[1];
    assign ACTIVE   = r_active;
    assign UNDERRUN = r_underrun;

`ifdef ODDR_GEARBOX_STATS_EN
    logic [STAT_W-1:0] r_word_cnt;
    logic [STAT_W-1:0] r_underrun_cnt;

    // Count at the edge that creates the event, so a frozen CE never double counts.
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            r_word_cnt     <= '0;
            r_underrun_cnt <= '0;
        end else if (CE) begin
            if (w_load && (r_word_cnt != {STAT_W{1'b1}}))
                r_word_cnt <= r_word_cnt + 1'b1;
            if (w_last && !w_hv && (r_underrun_cnt != {STAT_W{1'b1}}))
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end

    assign WORD_CNT     = r_word_cnt;
    assign UNDERRUN_CNT = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_oddr_gearbox.sv
// Self-checking bench: an 8-bit/INIT=0 lane against a queue-based beat model,
// plus a 2-bit/INIT=1 lane against a closed-form per-edge model.
module tb_oddr_gearbox;

    logic C = 1'b0;
    always #5 C = ~C;

    logic       r_n, ce, in_valid;
    logic [7:0] in_data;
    logic       in_ready, d1, d2, active, underrun;

    logic       r_n2, ce2, v2;
    logic [1:0] dat2;
    logic       ready2, d1_2, d2_2, active2, under2;

`ifdef ODDR_GEARBOX_STATS_EN
    logic [15:0] word_cnt, under_cnt, word_cnt2, under_cnt2;
`endif

    oddr_gearbox #(.DATA_W(8), .INIT(1'b0)) dut8 (
        .C(C), .R_N(r_n), .CE(ce), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready), .D1(d1), .D2(d2), .ACTIVE(active), .UNDERRUN(underrun)
`ifdef ODDR_GEARBOX_STATS_EN
        , .WORD_CNT(word_cnt), .UNDERRUN_CNT(under_cnt)
`endif
    );

    oddr_gearbox #(.DATA_W(2), .INIT(1'b1)) dut2 (
        .C(C), .R_N(r_n2), .CE(ce2), .IN_DATA(dat2), .IN_VALID(v2),
        .IN_READY(ready2), .D1(d1_2), .D2(d2_2), .ACTIVE(active2), .UNDERRUN(under2)
`ifdef ODDR_GEARBOX_STATS_EN
        , .WORD_CNT(word_cnt2), .UNDERRUN_CNT(under_cnt2)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model for the 8-bit lane: beats still to show (front = on the pins)
    // and words waiting in the single hold slot.
    logic [1:0] m_beats[$];
    logic [7:0] m_pend[$];
    logic       m_under;

    function automatic logic [4:0] exp_vec(input logic ce_i);
        logic       ld, rdy, act;
        logic [1:0] p;
        ld  = (m_pend.size() > 0) && (m_beats.size() <= 1);
        rdy = ce_i && ((m_pend.size() == 0) || ld);
        act = (m_beats.size() > 0);
        p   = act ? m_beats[0] : 2'b00;
        return {rdy, act, m_under, p[0], p[1]};
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d, input logic ce_i);
        logic       ld, rdy, was_last;
        logic [7:0] w;
        if (!ce_i) begin
            m_under = 1'b0;
            return;
        end
        ld       = (m_pend.size() > 0) && (m_beats.size() <= 1);
        rdy      = (m_pend.size() == 0) || ld;
        was_last = (m_beats.size() == 1);
        if (m_beats.size() > 0) void'(m_beats.pop_front());
        if (ld) begin
            w = m_pend.pop_front();
            for (int b = 0; b < 4; b++) m_beats.push_back(w[2*b +: 2]);
        end
        m_under = was_last && !ld;
        if (v && rdy) m_pend.push_back(d);
    endfunction

    function automatic void model_reset();
        m_beats.delete();
        m_pend.delete();
        m_under = 1'b0;
    endfunction

    task automatic tick();
        @(posedge C);
        model_step(in_valid, in_data, ce);
        @(negedge C);
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        r_n = 1'b0; r_n2 = 1'b0; ce = 1'b1; ce2 = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; v2 = 1'b0; dat2 = 2'b00;
        model_reset();
        repeat (2) @(negedge C);
        obs = {in_ready, active, underrun, d1, d2};
        vectors++;
        if (obs !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset8: got %b want %b", obs, 5'b10000);
        end
        vectors++;
        if ({active2, under2, d1_2, d2_2} !== 4'b0011) begin
            miscompares++;
            $display("FAIL reset2: got %b want %b", {active2, under2, d1_2, d2_2}, 4'b0011);
        end
        r_n = 1'b1; r_n2 = 1'b1;
        @(negedge C);
    endtask

    task automatic test_idle();
        logic [4:0] obs, exp;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b0; ce = 1'b1;
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp || exp !== 5'b10000) begin
                miscompares++;
                $display("FAIL idle cyc %0d: got %b want %b", i, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_single_word();
        logic [4:0] obs, exp;
        logic [1:0] seen[$];
        logic [7:0] want_seq;
        logic [7:0] got_seq;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i == 0); in_data = 8'hB4; ce = 1'b1;
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single cyc %0d: got %b want %b", i, obs, exp);
            end
            if (i >= 2 && i <= 5) seen.push_back({d1, d2});
            tick();
        end
        // Fixed expectation for 8'hB4: (0,0) (1,0) (1,1) (0,1).
        want_seq = 8'b00_10_11_01;
        got_seq  = 8'h00;
        for (int j = 0; j < seen.size(); j++) got_seq[7-2*j -: 2] = seen[j];
        vectors++;
        if (got_seq !== want_seq) begin
            miscompares++;
            $display("FAIL single_seq: got %b want %b", got_seq, want_seq);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs, exp;
        logic [7:0] words[3];
        int idx, act_cnt, und_cnt;
        logic acc;
        words = '{8'hFF, 8'h00, 8'hAA};
        idx = 0; act_cnt = 0; und_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            in_valid = (idx < 3); in_data = (idx < 3) ? words[idx] : 8'h00; ce = 1'b1;
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL b2b cyc %0d: got %b want %b", i, obs, exp);
            end
            if (active) act_cnt++;
            if (underrun) und_cnt++;
            acc = in_valid && exp[4];
            tick();
            if (acc) idx++;
        end
        vectors++;
        if (act_cnt !== 12 || und_cnt !== 1) begin
            miscompares++;
            $display("FAIL b2b_totals: active %0d underrun %0d want 12 1", act_cnt, und_cnt);
        end
    endtask

    task automatic test_ce_freeze();
        logic [4:0] obs, exp;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i == 0) || (i >= 3 && i <= 5);
            in_data  = (i == 0) ? 8'h5A : 8'hC3;
            ce       = !(i >= 3 && i <= 5);
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ce_freeze cyc %0d: got %b want %b", i, obs, exp);
            end
            tick();
        end
        in_valid = 1'b0; ce = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        logic [4:0] obs, exp;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 2); in_data = (i == 0) ? 8'h96 : 8'h3C; ce = 1'b1;
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pre_reset cyc %0d: got %b want %b", i, obs, exp);
            end
            tick();
        end
        in_valid = 1'b0;
        #2 r_n = 1'b0;
        #1;
        obs = {in_ready, active, underrun, d1, d2};
        vectors++;
        if (obs !== 5'b10000) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", obs, 5'b10000);
        end
`ifdef ODDR_GEARBOX_STATS_EN
        vectors++;
        if (word_cnt !== 16'd0 || under_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_reset: got %0d %0d want 0 0", word_cnt, under_cnt);
        end
`endif
        @(negedge C);
        r_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL post_reset cyc %0d: got %b want %b", i, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4:0] obs, exp;
        logic       acc;
        logic [7:0] hold_d;
        hold_d = 8'($urandom);
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = hold_d;
            ce       = ($urandom_range(0, 9) != 0);
            #1;
            obs = {in_ready, active, underrun, d1, d2};
            exp = exp_vec(ce);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, exp);
            end
            acc = in_valid && exp[4];
            tick();
            if (acc) hold_d = 8'($urandom);
        end
        in_valid = 1'b0; ce = 1'b1;
        repeat (6) tick();
    endtask

    // Two-bit lane: every edge can load, so the pins trail the handshake by exactly two edges.
    task automatic test_dw2();
        logic [1:0] stream[3];
        logic       pa1, pa2, pa3;
        logic [1:0] pd1, pd2;
        logic [4:0] obs, exp;
        logic [1:0] dexp;
        stream = '{2'b01, 2'b10, 2'b11};
        pa1 = 1'b0; pa2 = 1'b0; pa3 = 1'b0; pd1 = 2'b11; pd2 = 2'b11;
        for (int i = 0; i < 50; i++) begin
            if (i < 3) begin
                v2 = 1'b1; dat2 = stream[i];
            end else if (i < 7) begin
                v2 = 1'b0; dat2 = 2'b00;
            end else begin
                v2 = ($urandom_range(0, 3) != 0); dat2 = 2'($urandom_range(0, 3));
            end
            #1;
            dexp = pa2 ? pd2 : 2'b11;
            exp  = {1'b1, pa2, pa3 && !pa2, dexp[0], dexp[1]};
            obs  = {ready2, active2, under2, d1_2, d2_2};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL dw2 cyc %0d: got %b want %b", i, obs, exp);
            end
            @(posedge C);
            pa3 = pa2; pa2 = pa1; pd2 = pd1; pa1 = v2; pd1 = dat2;
            @(negedge C);
        end
        v2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_dw2();
        test_single_word();
        test_back_to_back();
        test_ce_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
